hdmi_period_scheduler: RTL and testbench

Pixel-clock scheduler that sits directly upstream of the three per-channel TMDS encoders. It owns the raster counters and decides, every pixel clock, which HDMI period the encoders emit: control, video preamble, video guard band, video, data-island preamble, data-island guard band, or data-island packet. It drives the shared encoder mode and the per-channel control bits, and issues one-cycle-ahead request strobes so the pixel source and packet assembler can register their data in alignment.

---
 rtl/hdmi_period_scheduler.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
//
// Pixel-clock period scheduler for an HDMI/DVI transmitter. It owns the
// raster counters and, every pixel clock, selects which period the three
// TMDS encoders emit: control, video preamble, video guard band, video,
// data-island preamble, data-island guard band or data-island packet.
// Request strobes lead their period by one clock so that the pixel source
// and the packet assembler can register their data in alignment.
//
// Configuration macro: HDMI_DATA_ISLAND_EN
//   defined   - full HDMI behaviour (video preamble/guard, data islands)
//   undefined - DVI behaviour (control and video periods only)
//
// Ports:
//   clk_pixel    in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   packet_valid in   assembler holds NUM_PACKETS packets for this line
//   mode         out  0 control, 1 video, 2 video guard, 3 island, 4 island guard
//   ctl0         out  {vsync, hsync} for channel 0
//   ctl1         out  {CTL1, CTL0} for channel 1
//   ctl2         out  {CTL3, CTL2} for channel 2
//   cx           out  horizontal counter, 0 = first active pixel
//   cy           out  vertical counter, 0 = first active line
//   video_req    out  next cycle is a video cycle
//   island_req   out  next cycle is a data-island packet cycle
//   island_pos   out  cycle index 0..31 within the packet of the next cycle
//   packet_idx   out  packet index of the next cycle
//   packet_start out  island_req with island_pos == 0

module hdmi_period_scheduler #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter bit SYNC_POL      = 1'b0,
    parameter int ISLAND_OFFSET = 4,
    parameter int NUM_PACKETS   = 2
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        packet_valid,
    output logic [2:0]  mode,
    output logic [1:0]  ctl0,
    output logic [1:0]  ctl1,
    output logic [1:0]  ctl2,
    output logic [11:0] cx,
    output logic [10:0] cy,
    output logic        video_req,
    output logic        island_req,
    output logic [4:0]  island_pos,
    output logic [4:0]  packet_idx,
    output logic        packet_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST        = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT         = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START      = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END        = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST        = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT         = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START      = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END        = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_ISLAND = 3'd3;
    localparam logic [2:0] MODE_IGUARD = 3'd4;

    // Reject raster geometries the scheduler cannot honour.
`ifdef HDMI_DATA_ISLAND_EN
    if ((H_ACTIVE + ISLAND_OFFSET + 12 + 32 * NUM_PACKETS + 12 > H_TOTAL - 10) ||
        (ISLAND_OFFSET < 1) || (NUM_PACKETS < 1) || (NUM_PACKETS > 18)) begin : g_cfg_error
        $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
    end
`else
    if (H_TOTAL <= H_ACTIVE) begin : g_cfg_error
        $error("hdmi_period_scheduler: H_TOTAL must exceed H_ACTIVE");
    end
`endif

    function automatic logic [11:0] next_x(input logic [11:0] x);
        return (x == H_LAST) ? 12'd0 : x + 12'd1;
    endfunction

    function automatic logic [10:0] next_y(input logic [11:0] x, input logic [10:0] y);
        if (x != H_LAST)
            return y;
        return (y == V_LAST) ? 11'd0 : y + 11'd1;
    endfunction

    function automatic logic next_line_active(input logic [10:0] y);
        return (y == V_LAST) || ((y + 11'd1) < V_ACT);
    endfunction

    // Outputs are registered, so everything is computed for the coming
    // cycle (nx_*); the request strobes look one cycle further (nn_*).
    logic [11:0] nx_cx;
    logic [11:0] nn_cx;
    logic [10:0] nx_cy;
    logic [10:0] nn_cy;

    always_comb begin
        nx_cx = next_x(cx);
        nx_cy = next_y(cx, cy);
        nn_cx = next_x(nx_cx);
        nn_cy = next_y(nx_cx, nx_cy);
    end

    logic       hs_on;
    logic       vs_on;
    logic [1:0] ctl0_d;
    logic       video_req_d;

    assign hs_on       = (nx_cx >= HS_START) && (nx_cx < HS_END);
    assign vs_on       = (nx_cy >= VS_START) && (nx_cy < VS_END);
    assign ctl0_d      = {(vs_on ? SYNC_POL : ~SYNC_POL), (hs_on ? SYNC_POL : ~SYNC_POL)};
    assign video_req_d = (nn_cx < H_ACT) && (nn_cy < V_ACT);

    logic       island_req_d;
    logic [4:0] island_pos_d;
    logic [4:0] packet_idx_d;
    logic       packet_start_d;

`ifdef HDMI_DATA_ISLAND_EN
    localparam logic [11:0] SAMPLE_X      = 12'(H_ACTIVE + ISLAND_OFFSET - 1);
    localparam logic [11:0] PRE_V_START   = 12'(H_TOTAL - 10);
    localparam logic [11:0] GUARD_V_START = 12'(H_TOTAL - 2);
    localparam logic [9:0]  DATA_LAST     = 10'(32 * NUM_PACKETS - 1);

    typedef enum logic [2:0] {
        ISL_IDLE,
        ISL_PRE,
        ISL_GUARD_L,
        ISL_DATA,
        ISL_GUARD_T
    } island_state_t;

    // isl_state/isl_cnt describe the cycle currently shown on the outputs.
    island_state_t isl_state;
    island_state_t isl_state_nx;
    logic [9:0]    isl_cnt;
    logic [9:0]    isl_cnt_nx;
    logic [9:0]    data_pos_nn;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            isl_state <= ISL_IDLE;
            isl_cnt   <= '0;
        end else begin
            isl_state <= isl_state_nx;
            isl_cnt   <= isl_cnt_nx;
        end
    end

    // packet_valid only matters on the single sample cycle; once an island
    // is committed it always runs to completion.
    always_comb begin
        isl_state_nx = isl_state;
        isl_cnt_nx   = isl_cnt + 10'd1;
        case (isl_state)
            ISL_IDLE: begin
                isl_cnt_nx = '0;
                if ((cx == SAMPLE_X) && packet_valid)
                    isl_state_nx = ISL_PRE;
            end
            ISL_PRE: begin
                if (isl_cnt == 10'd7) begin
                    isl_state_nx = ISL_GUARD_L;
                    isl_cnt_nx   = '0;
                end
            end
            ISL_GUARD_L: begin
                if (isl_cnt == 10'd1) begin
                    isl_state_nx = ISL_DATA;
                    isl_cnt_nx   = '0;
                end
            end
            ISL_DATA: begin
                if (isl_cnt == DATA_LAST) begin
                    isl_state_nx = ISL_GUARD_T;
                    isl_cnt_nx   = '0;
                end
            end
            ISL_GUARD_T: begin
                if (isl_cnt == 10'd1) begin
                    isl_state_nx = ISL_IDLE;
                    isl_cnt_nx   = '0;
                end
            end
            default: begin
                isl_state_nx = ISL_IDLE;
                isl_cnt_nx   = '0;
            end
        endcase
    end

    // The strobes describe the cycle after the coming one: the last
    // leading-guard cycle announces data position 0, and each data cycle
    // except the last announces its successor.
    always_comb begin
        data_pos_nn    = (isl_state_nx == ISL_GUARD_L) ? 10'd0 : isl_cnt_nx + 10'd1;
        island_req_d   = ((isl_state_nx == ISL_GUARD_L) && (isl_cnt_nx == 10'd1)) ||
                         ((isl_state_nx == ISL_DATA) && (isl_cnt_nx != DATA_LAST));
        island_pos_d   = island_req_d ? data_pos_nn[4:0] : 5'd0;
        packet_idx_d   = island_req_d ? data_pos_nn[9:5] : 5'd0;
        packet_start_d = island_req_d && (data_pos_nn[4:0] == 5'd0);
    end
`else
    logic dvi_unused;

    assign dvi_unused     = packet_valid;
    assign island_req_d   = 1'b0;
    assign island_pos_d   = 5'd0;
    assign packet_idx_d   = 5'd0;
    assign packet_start_d = 1'b0;
`endif

    logic [2:0] mode_d;
    logic [1:0] ctl1_d;
    logic [1:0] ctl2_d;

    // Islands live entirely inside horizontal blanking and end before the
    // video preamble window, so the priority order never hides a period.
    always_comb begin
        mode_d = MODE_CTRL;
        ctl1_d = 2'b00;
        ctl2_d = 2'b00;
        if ((nx_cx < H_ACT) && (nx_cy < V_ACT)) begin
            mode_d = MODE_VIDEO;
        end
`ifdef HDMI_DATA_ISLAND_EN
        else if (isl_state_nx == ISL_PRE) begin
            ctl1_d = 2'b01;
            ctl2_d = 2'b01;
        end else if ((isl_state_nx == ISL_GUARD_L) || (isl_state_nx == ISL_GUARD_T)) begin
            mode_d = MODE_IGUARD;
        end else if (isl_state_nx == ISL_DATA) begin
            mode_d = MODE_ISLAND;
        end else if (next_line_active(nx_cy) && (nx_cx >= GUARD_V_START)) begin
            mode_d = MODE_VGUARD;
        end else if (next_line_active(nx_cy) && (nx_cx >= PRE_V_START)) begin
            ctl1_d = 2'b01;
        end
`endif
    end

    // video_req resets high because the cycle after reset (cx=1, cy=0) is
    // already active video with no preamble.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            cx           <= '0;
            cy           <= '0;
            mode         <= MODE_CTRL;
            ctl0         <= {~SYNC_POL, ~SYNC_POL};
            ctl1         <= 2'b00;
            ctl2         <= 2'b00;
            video_req    <= 1'b1;
            island_req   <= 1'b0;
            island_pos   <= 5'd0;
            packet_idx   <= 5'd0;
            packet_start <= 1'b0;
        end else begin
            cx           <= nx_cx;
            cy           <= nx_cy;
            mode         <= mode_d;
            ctl0         <= ctl0_d;
            ctl1         <= ctl1_d;
            ctl2         <= ctl2_d;
            video_req    <= video_req_d;
            island_req   <= island_req_d;
            island_pos   <= island_pos_d;
            packet_idx   <= packet_idx_d;
            packet_start <= packet_start_d;
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler
//
// Self-checking bench for hdmi_period_scheduler. Horizontal timing is the
// default 640x480 raster; the vertical geometry is shortened (12 active
// lines, 19 total) so that whole frames stay short. Each applied cycle
// pushes the expected outputs, derived from raster arithmetic, onto a
// queue; a separate monitor pops and compares at the falling clock edge.
// Works with or without HDMI_DATA_ISLAND_EN.

module tb_hdmi_period_scheduler;

    localparam int HA  = 640;
    localparam int HF  = 16;
    localparam int HS  = 96;
    localparam int HB  = 48;
    localparam int VA  = 12;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam bit POL = 1'b0;
    localparam int OFS = 4;
    localparam int NP  = 2;

    localparam int SAMPLE_X = HA + OFS - 1;
    localparam int ISL_X    = HA + OFS;
    localparam int DATA_X   = ISL_X + 10;
    localparam int DATA_END = DATA_X + 32 * NP;

`ifdef HDMI_DATA_ISLAND_EN
    localparam bit HDMI = 1'b1;
`else
    localparam bit HDMI = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] cx;
        logic [10:0] cy;
        logic [2:0]  mode;
        logic [1:0]  ctl0;
        logic [1:0]  ctl1;
        logic [1:0]  ctl2;
        logic        video_req;
        logic        island_req;
        logic [4:0]  island_pos;
        logic [4:0]  packet_idx;
        logic        packet_start;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        packet_valid;
    logic [2:0]  mode;
    logic [1:0]  ctl0;
    logic [1:0]  ctl1;
    logic [1:0]  ctl2;
    logic [11:0] cx;
    logic [10:0] cy;
    logic        video_req;
    logic        island_req;
    logic [4:0]  island_pos;
    logic [4:0]  packet_idx;
    logic        packet_start;

    obs_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   k           = 0;
    bit   lineIsland  = 1'b0;
    event sampleEv;

    hdmi_period_scheduler #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .ISLAND_OFFSET(OFS), .NUM_PACKETS(NP)
    ) dut (
        .clk_pixel(clk),
        .rst_n(rst_n),
        .packet_valid(packet_valid),
        .mode(mode),
        .ctl0(ctl0),
        .ctl1(ctl1),
        .ctl2(ctl2),
        .cx(cx),
        .cy(cy),
        .video_req(video_req),
        .island_req(island_req),
        .island_pos(island_pos),
        .packet_idx(packet_idx),
        .packet_start(packet_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t resetState();
        obs_t e;
        e           = '0;
        e.ctl0      = {~POL, ~POL};
        e.video_req = 1'b1;
        return e;
    endfunction

    // {mode, ctl1, ctl2} of the cycle at raster position (x, y).
    function automatic logic [6:0] periodAt(input int x, input int y, input bit flag);
        bit nextActive;
        nextActive = ((y + 1) % VT) < VA;
        if (x < HA && y < VA)                              return {3'd1, 2'b00, 2'b00};
        if (!HDMI)                                         return 7'd0;
        if (flag && x >= ISL_X && x < ISL_X + 8)           return {3'd0, 2'b01, 2'b01};
        if (flag && x >= ISL_X + 8 && x < DATA_X)          return {3'd4, 2'b00, 2'b00};
        if (flag && x >= DATA_X && x < DATA_END)           return {3'd3, 2'b00, 2'b00};
        if (flag && x >= DATA_END && x < DATA_END + 2)     return {3'd4, 2'b00, 2'b00};
        if (nextActive && x >= HT - 2)                     return {3'd2, 2'b00, 2'b00};
        if (nextActive && x >= HT - 10)                    return {3'd0, 2'b01, 2'b00};
        return 7'd0;
    endfunction

    // Expected outputs for the k-th cycle after reset release.
    function automatic obs_t modelCycle(input int kk, input bit flag);
        obs_t       e;
        int         x, y, x1, y1, pos;
        logic [6:0] p;
        bit         hsOn, vsOn;
        x  = kk % HT;
        y  = (kk / HT) % VT;
        x1 = (kk + 1) % HT;
        y1 = ((kk + 1) / HT) % VT;
        e  = '0;
        e.cx = 12'(x);
        e.cy = 11'(y);
        p = periodAt(x, y, flag);
        e.mode = p[6:4];
        e.ctl1 = p[3:2];
        e.ctl2 = p[1:0];
        hsOn = (x >= HA + HF) && (x < HA + HF + HS);
        vsOn = (y >= VA + VF) && (y < VA + VF + VS);
        e.ctl0 = {(vsOn ? POL : ~POL), (hsOn ? POL : ~POL)};
        e.video_req = (x1 < HA) && (y1 < VA);
        if (HDMI && flag && x1 >= DATA_X && x1 < DATA_END) begin
            pos            = x1 - DATA_X;
            e.island_req   = 1'b1;
            e.island_pos   = 5'(pos % 32);
            e.packet_idx   = 5'(pos / 32);
            e.packet_start = (pos % 32) == 0;
        end
        return e;
    endfunction

    function automatic bit pickValid(input int x, input int y);
        if (x == SAMPLE_X) begin
            case (y)
                4, 10, 15: return 1'b1;
                11:        return 1'b0;
                default:   return 1'($urandom_range(0, 1));
            endcase
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input obs_t e);
        obs_t act;
        act = {cx, cy, mode, ctl0, ctl1, ctl2, video_req, island_req,
               island_pos, packet_idx, packet_start};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("[TB] FAIL outputs at cx=%0d cy=%0d: got mode=%0d ctl0=%b ctl1=%b ctl2=%b vreq=%b ireq=%b pos=%0d idx=%0d start=%b (cx=%0d cy=%0d), expected mode=%0d ctl0=%b ctl1=%b ctl2=%b vreq=%b ireq=%b pos=%0d idx=%0d start=%b",
                     e.cx, e.cy, act.mode, act.ctl0, act.ctl1, act.ctl2, act.video_req,
                     act.island_req, act.island_pos, act.packet_idx, act.packet_start,
                     act.cx, act.cy, e.mode, e.ctl0, e.ctl1, e.ctl2, e.video_req,
                     e.island_req, e.island_pos, e.packet_idx, e.packet_start);
        end
    endtask

    // Drives one random packet_valid per cycle and records the response the
    // DUT owes for the cycle now on its outputs.
    task automatic applyStimulus(input int n);
        int x, y;
        bit pv;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
            x = k % HT;
            y = (k / HT) % VT;
            if (x == 0)
                lineIsland = 1'b0;
            expQ.push_back(modelCycle(k, lineIsland));
            pv = pickValid(x, y);
            packet_valid = pv;
            if (x == SAMPLE_X)
                lineIsland = pv;
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk or sampleEv);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        rst_n        = 1'b0;
        packet_valid = 1'b0;
        #3;
        expQ.push_back(resetState());
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        $display("[TB] reset released, running one frame plus four lines");

        applyStimulus(HT * VT + 4 * HT + 670);

        // Reset pulse in the middle of line 4's island.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expQ.push_back(resetState());
        ->sampleEv;
        @(posedge clk);
        #1;
        expQ.push_back(resetState());
        @(negedge clk);
        #2;
        rst_n      = 1'b1;
        k          = 0;
        lineIsland = 1'b0;
        $display("[TB] reset pulse done, restarting raster");

        applyStimulus(HT * 7);

        for (int w = 0; w < 10 && expQ.size() > 0; w++)
            @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
